nic_pe_port: RTL

- Network interface controller between a processing element (PE) and the router's PE port.
- Drives the router's PE input (pesi/pedi/peri) and accepts the router's PE output (peso/pedo/pero), using the router's send/ready handshake.
- Gives the PE a 4-address register interface: one input channel buffer, one output channel buffer, and a status word for each.
- Injection into the router is gated by the router's polarity signal and the packet's virtual-channel bit.

---
 rtl/nic_pkg.sv | 27 ++
 rtl/nic_chan_buf.sv | 42 ++++
 rtl/nic_pe_port.sv | 84 ++++++++
 3 files changed

// File: rtl/nic_pkg.sv
// Shared constants and types for the PE-side network interface controller.
// Both channel buffers and the top-level register decode import this package.
package nic_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 2;
  localparam int VC_BIT = DATA_W - 1;

  localparam logic [ADDR_W-1:0] ADDR_IN_BUF   = 2'b00;
  localparam logic [ADDR_W-1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [ADDR_W-1:0] ADDR_OUT_BUF  = 2'b10;
  localparam logic [ADDR_W-1:0] ADDR_OUT_STAT = 2'b11;

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } chan_state_t;

  // Status registers report the full flag in bit 0, all other bits zero.
  function automatic logic [DATA_W-1:0] status_word(input logic full);
    logic [DATA_W-1:0] w;
    w    = '0;
    w[0] = full;
    return w;
  endfunction

endpackage

// File: rtl/nic_chan_buf.sv
// One-entry channel buffer: a data register plus a two-state EMPTY/FULL FSM.
// The full output is the FSM state itself, so it doubles as the state probe.
module nic_chan_buf
  import nic_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              clear,
  output logic [DATA_W-1:0] data,
  output logic              full
);

  chan_state_t state, state_nxt;
  logic        take;

  // A load is only accepted while empty; a load against a full buffer is dropped.
  assign take = load && (state == CH_EMPTY);

  always_comb begin
    state_nxt = state;
    case (state)
      CH_EMPTY: if (load)  state_nxt = CH_FULL;
      CH_FULL:  if (clear) state_nxt = CH_EMPTY;
      default:             state_nxt = CH_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= CH_EMPTY;
      data  <= '0;
    end else begin
      state <= state_nxt;
      if (take) data <= load_data;
    end
  end

  assign full = (state == CH_FULL);

endmodule

// File: rtl/nic_pe_port.sv
// NIC between a processing element and the router PE port: a 4-address PE
// register file over one input and one output channel buffer.
module nic_pe_port
  import nic_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              polarity,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              nic_en,
  input  logic              nic_wr_en,
  output logic              net_so,
  input  logic              net_ro,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [DATA_W-1:0] net_di
);

  logic              pe_rd;
  logic              pe_wr;
  logic              in_load;
  logic              in_clear;
  logic              in_full;
  logic [DATA_W-1:0] in_buf;
  logic              out_load;
  logic              out_clear;
  logic              out_full;
  logic [DATA_W-1:0] out_buf;

  assign pe_rd = nic_en && !nic_wr_en;
  assign pe_wr = nic_en &&  nic_wr_en;

  // Router handshake: a transfer happens on a posedge where the sender's
  // strobe (net_si / net_so) is high and the receiver's ready is high. The
  // strobe must only be raised while ready is high; a strobe without ready
  // is ignored.
  assign net_ri = reset && !in_full;
  assign net_so = reset && out_full && net_ro && (polarity == out_buf[VC_BIT]);
  assign net_do = out_buf;

  assign in_load   = net_si && net_ri;
  assign in_clear  = pe_rd && (addr == ADDR_IN_BUF);
  // Write sees the registered out_full, so a write in the send cycle is dropped.
  assign out_load  = pe_wr && (addr == ADDR_OUT_BUF) && !out_full;
  assign out_clear = net_so;

  nic_chan_buf u_in_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (in_load),
    .load_data (net_di),
    .clear     (in_clear),
    .data      (in_buf),
    .full      (in_full)
  );

  nic_chan_buf u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (out_load),
    .load_data (d_in),
    .clear     (out_clear),
    .data      (out_buf),
    .full      (out_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_out <= '0;
    end else if (pe_rd) begin
      case (addr)
        ADDR_IN_BUF:   d_out <= in_buf;
        ADDR_IN_STAT:  d_out <= status_word(in_full);
        ADDR_OUT_BUF:  d_out <= out_buf;
        ADDR_OUT_STAT: d_out <= status_word(out_full);
        default:       d_out <= '0;
      endcase
    end
  end

endmodule
